// File: rtl/rx_buf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_buf_pkg                                                           |
// | Shared types and helpers for the receive frame buffer.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rx_buf_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_RECV = 2'd1,
    WR_DROP = 2'd2
  } wr_state_t;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_len_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_len_fifo                                                          |
// | Synchronous FIFO holding the lengths of committed frames.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rx_len_fifo
  import rx_buf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q;
  logic [PW:0]      rd_ptr_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;

  // Extra MSB on each pointer distinguishes full from empty.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q[PW-1:0]] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/rx_frame_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_frame_buffer                                                      |
// | Circular byte buffer committing good MAC RX frames for the checker.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rx_frame_buffer
  import rx_buf_pkg::*;
#(
  parameter int SIZE       = 2048,
  parameter int MAX_FRAMES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_axis_tdata,
  input  logic                    rx_axis_tvalid,
  input  logic                    rx_axis_tlast,
  input  logic                    rx_axis_tuser,
  input  logic                    brx_rd_en,
  output logic [7:0]              brx_data,
  output logic                    brx_valid,
  output logic                    brx_last,
  output logic                    brx_frame_avail,
  output logic [$clog2(SIZE)-1:0] brx_frame_len,
  output logic [CNT_W-1:0]        good_count,
  output logic [CNT_W-1:0]        drop_count
);

  localparam int AW = $clog2(SIZE);

  logic [7:0]       mem_q [SIZE];

  wr_state_t        wr_state_q, wr_state_d;
  logic [AW-1:0]    wptr_work_q, wptr_work_d;
  logic [AW-1:0]    wptr_commit_q, wptr_commit_d;
  logic [AW-1:0]    wr_len_q, wr_len_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  rd_state_t        rd_state_q, rd_state_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW-1:0]    rem_q, rem_d;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             last_q;

  logic [AW-1:0]    w_wptr_inc;
  logic [AW-1:0]    w_len_next;
  logic             w_blocked;
  logic             w_mem_we;
  logic             w_push;
  logic             w_pop;
  logic             w_rd_fire;
  logic             w_rd_last;
  logic [AW-1:0]    w_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;

  rx_len_fifo #(
    .DEPTH (MAX_FRAMES),
    .WIDTH (AW)
  ) u_len_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .data_i  (w_len_next),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  assign w_wptr_inc = wptr_work_q + 1'b1;
  assign w_len_next = (wr_state_q == WR_IDLE) ? AW'(1) : wr_len_q + 1'b1;
  // One slot is always kept free so that work == rptr means empty.
  assign w_blocked  = (w_wptr_inc == rptr_q) || (rx_axis_tlast && w_fifo_full);

  always_comb begin
    wr_state_d    = wr_state_q;
    wptr_work_d   = wptr_work_q;
    wptr_commit_d = wptr_commit_q;
    wr_len_d      = wr_len_q;
    good_d        = good_q;
    drop_d        = drop_q;
    w_mem_we      = 1'b0;
    w_push        = 1'b0;
    if (rx_axis_tvalid) begin
      case (wr_state_q)
        WR_IDLE, WR_RECV: begin
          if (rx_axis_tlast && (w_blocked || rx_axis_tuser)) begin
            wptr_work_d = wptr_commit_q;
            drop_d      = sat_inc(drop_q);
            wr_state_d  = WR_IDLE;
          end else if (w_blocked) begin
            wr_state_d = WR_DROP;
          end else begin
            w_mem_we    = 1'b1;
            wptr_work_d = w_wptr_inc;
            wr_len_d    = w_len_next;
            if (rx_axis_tlast) begin
              wptr_commit_d = w_wptr_inc;
              w_push        = 1'b1;
              good_d        = sat_inc(good_q);
              wr_state_d    = WR_IDLE;
            end else begin
              wr_state_d = WR_RECV;
            end
          end
        end
        WR_DROP: begin
          if (rx_axis_tlast) begin
            wptr_work_d = wptr_commit_q;
            drop_d      = sat_inc(drop_q);
            wr_state_d  = WR_IDLE;
          end
        end
        default: wr_state_d = WR_IDLE;
      endcase
    end
  end

  // rem holds the bytes still owed after the one being read this cycle.
  always_comb begin
    rd_state_d = rd_state_q;
    rem_d      = rem_q;
    w_rd_fire  = 1'b0;
    w_rd_last  = 1'b0;
    w_pop      = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (brx_rd_en && !w_fifo_empty) begin
          w_rd_fire = 1'b1;
          if (w_head == AW'(1)) begin
            w_rd_last = 1'b1;
            w_pop     = 1'b1;
          end else begin
            rem_d      = w_head - 1'b1;
            rd_state_d = RD_READ;
          end
        end
      end
      RD_READ: begin
        if (brx_rd_en) begin
          w_rd_fire = 1'b1;
          if (rem_q == AW'(1)) begin
            w_rd_last  = 1'b1;
            w_pop      = 1'b1;
            rd_state_d = RD_IDLE;
          end else begin
            rem_d = rem_q - 1'b1;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    rptr_d = w_rd_fire ? rptr_q + 1'b1 : rptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q    <= WR_IDLE;
      wptr_work_q   <= '0;
      wptr_commit_q <= '0;
      wr_len_q      <= '0;
      good_q        <= '0;
      drop_q        <= '0;
      rd_state_q    <= RD_IDLE;
      rptr_q        <= '0;
      rem_q         <= '0;
      data_q        <= 8'h00;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
    end else begin
      wr_state_q    <= wr_state_d;
      wptr_work_q   <= wptr_work_d;
      wptr_commit_q <= wptr_commit_d;
      wr_len_q      <= wr_len_d;
      good_q        <= good_d;
      drop_q        <= drop_d;
      rd_state_q    <= rd_state_d;
      rptr_q        <= rptr_d;
      rem_q         <= rem_d;
      valid_q       <= w_rd_fire;
      last_q        <= w_rd_last;
      if (w_rd_fire) data_q <= mem_q[rptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) mem_q[wptr_work_q] <= rx_axis_tdata;
  end

  assign brx_data        = data_q;
  assign brx_valid       = valid_q;
  assign brx_last        = last_q;
  assign brx_frame_avail = !w_fifo_empty;
  assign brx_frame_len   = w_fifo_empty ? '0 : w_head;
  assign good_count      = good_q;
  assign drop_count      = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rx_frame_buffer                                                   |
// | Two buffer instances (full size and small) against a frame model.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_rx_frame_buffer;

  localparam int SZ0 = 2048;
  localparam int MF0 = 16;
  localparam int SZ1 = 64;
  localparam int MF1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst    [2];
  logic [7:0] tdata  [2];
  logic       tvalid [2];
  logic       tlast  [2];
  logic       tuser  [2];
  logic       rd_en  [2];
  logic [7:0] bdata  [2];
  logic       bvalid [2];
  logic       blast  [2];
  logic       bavail [2];
  logic [15:0] gcnt  [2];
  logic [15:0] dcnt  [2];
  logic [10:0] blen0;
  logic [5:0]  blen1;
  int          flen  [2];

  always_comb begin
    flen[0] = int'(blen0);
    flen[1] = int'(blen1);
  end

  rx_frame_buffer #(.SIZE(SZ0), .MAX_FRAMES(MF0)) dut0 (
    .clk(clk), .rst(rst[0]),
    .rx_axis_tdata(tdata[0]), .rx_axis_tvalid(tvalid[0]),
    .rx_axis_tlast(tlast[0]), .rx_axis_tuser(tuser[0]),
    .brx_rd_en(rd_en[0]), .brx_data(bdata[0]), .brx_valid(bvalid[0]),
    .brx_last(blast[0]), .brx_frame_avail(bavail[0]), .brx_frame_len(blen0),
    .good_count(gcnt[0]), .drop_count(dcnt[0])
  );

  rx_frame_buffer #(.SIZE(SZ1), .MAX_FRAMES(MF1)) dut1 (
    .clk(clk), .rst(rst[1]),
    .rx_axis_tdata(tdata[1]), .rx_axis_tvalid(tvalid[1]),
    .rx_axis_tlast(tlast[1]), .rx_axis_tuser(tuser[1]),
    .brx_rd_en(rd_en[1]), .brx_data(bdata[1]), .brx_valid(bvalid[1]),
    .brx_last(blast[1]), .brx_frame_avail(bavail[1]), .brx_frame_len(blen1),
    .good_count(gcnt[1]), .drop_count(dcnt[1])
  );

  int total = 0;
  int bad   = 0;

  // Reference model: committed frames still waiting to be read.
  logic [7:0] fbytes [$];
  logic [7:0] mbytes [$];
  int         mlens  [$];
  int         mocc;
  int         eg;
  int         ed;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_frame(input int d, input bit badf);
    int cap;
    int mf;
    cap = (d == 0 ? SZ0 : SZ1) - 1;
    mf  = (d == 0 ? MF0 : MF1);
    if (!badf && fbytes.size() <= cap - mocc && mlens.size() < mf) begin
      mlens.push_back(fbytes.size());
      foreach (fbytes[i]) mbytes.push_back(fbytes[i]);
      mocc += fbytes.size();
      eg++;
    end else begin
      ed++;
    end
  endfunction

  task automatic do_reset(input int d);
    rst[d] = 1'b1; tvalid[d] = 1'b0; tlast[d] = 1'b0; tuser[d] = 1'b0; rd_en[d] = 1'b0;
    tick();
    tick();
    rst[d] = 1'b0;
    mlens.delete(); mbytes.delete(); mocc = 0; eg = 0; ed = 0;
  endtask

  task automatic fill_seq(input int len, input int start);
    fbytes.delete();
    for (int i = 0; i < len; i++) fbytes.push_back(8'((start + i) & 255));
  endtask

  task automatic fill_rand(input int len);
    fbytes.delete();
    for (int i = 0; i < len; i++) fbytes.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic send_frame(input int d, input bit badf, input bit gaps, input bit do_last);
    for (int i = 0; i < fbytes.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        tvalid[d] = 1'b0;
        tick();
      end
      tvalid[d] = 1'b1;
      tdata[d]  = fbytes[i];
      tlast[d]  = do_last && (i == fbytes.size() - 1);
      tuser[d]  = badf && tlast[d];
      tick();
    end
    tvalid[d] = 1'b0; tlast[d] = 1'b0; tuser[d] = 1'b0;
    if (do_last) model_frame(d, badf);
  endtask

  task automatic read_frame(input int d, input bit gaps, input string tag);
    int L;
    int issued;
    int got;
    int cyc;
    bit prev;
    logic [7:0] exp [$];
    L = mlens.pop_front();
    for (int i = 0; i < L; i++) exp.push_back(mbytes.pop_front());
    mocc -= L;
    total++;
    if (bavail[d] !== 1'b1) begin
      bad++; $display("FAIL %s_avail d=%0d got=%b exp=1", tag, d, bavail[d]);
    end
    total++;
    if (flen[d] !== L) begin
      bad++; $display("FAIL %s_len d=%0d got=%0d exp=%0d", tag, d, flen[d], L);
    end
    issued = 0; got = 0; cyc = 0;
    while (got < L && cyc < 4 * L + 20) begin
      prev = (issued < L) && (!gaps || $urandom_range(0, 3) != 0);
      rd_en[d] = prev;
      if (prev) issued++;
      tick();
      cyc++;
      total++;
      if (bvalid[d] !== prev) begin
        bad++; $display("FAIL %s_valid d=%0d byte=%0d got=%b exp=%b", tag, d, got, bvalid[d], prev);
      end
      if (bvalid[d] === 1'b1 && got < L) begin
        total++;
        if (bdata[d] !== exp[got]) begin
          bad++; $display("FAIL %s_data d=%0d byte=%0d got=%h exp=%h", tag, d, got, bdata[d], exp[got]);
        end
        total++;
        if (blast[d] !== 1'(got == L - 1)) begin
          bad++; $display("FAIL %s_last d=%0d byte=%0d got=%b exp=%b", tag, d, got, blast[d], got == L - 1);
        end
        got++;
      end
    end
    rd_en[d] = 1'b0;
    total++;
    if (got != L) begin
      bad++; $display("FAIL %s_timeout d=%0d got=%0d bytes exp=%0d", tag, d, got, L);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      do_reset(d);
      total++;
      if ({bdata[d], bvalid[d], blast[d], bavail[d]} !== 11'h000) begin
        bad++; $display("FAIL reset_outs d=%0d got=%h exp=000", d, {bdata[d], bvalid[d], blast[d], bavail[d]});
      end
      total++;
      if (flen[d] !== 0 || gcnt[d] !== 16'h0 || dcnt[d] !== 16'h0) begin
        bad++; $display("FAIL reset_cnt d=%0d len=%0d good=%0d drop=%0d exp=0", d, flen[d], gcnt[d], dcnt[d]);
      end
      rd_en[d] = 1'b1;
      tick();
      rd_en[d] = 1'b0;
      total++;
      if (bvalid[d] !== 1'b0) begin
        bad++; $display("FAIL reset_rd_empty d=%0d got=%b exp=0", d, bvalid[d]);
      end
    end
  endtask

  task automatic test_good_frame();
    do_reset(0);
    fill_seq(64, 0);
    send_frame(0, 1'b0, 1'b0, 1'b1);
    total++;
    if (gcnt[0] !== 16'd1 || flen[0] !== 64) begin
      bad++; $display("FAIL good_frame good=%0d len=%0d exp=1/64", gcnt[0], flen[0]);
    end
    read_frame(0, 1'b0, "good");
    total++;
    if (bavail[0] !== 1'b0) begin
      bad++; $display("FAIL good_drained got=%b exp=0", bavail[0]);
    end
  endtask

  task automatic test_bad_frame();
    do_reset(0);
    fill_rand(60);
    send_frame(0, 1'b1, 1'b0, 1'b1);
    fill_seq(10, 8'h80);
    send_frame(0, 1'b0, 1'b0, 1'b1);
    total++;
    if (dcnt[0] !== 16'd1 || gcnt[0] !== 16'd1 || flen[0] !== 10) begin
      bad++; $display("FAIL bad_frame drop=%0d good=%0d len=%0d exp=1/1/10", dcnt[0], gcnt[0], flen[0]);
    end
    read_frame(0, 1'b0, "bad");
    total++;
    if (bavail[0] !== 1'b0) begin
      bad++; $display("FAIL bad_drained got=%b exp=0", bavail[0]);
    end
  endtask

  task automatic test_overflow();
    do_reset(1);
    fill_seq(70, 0);
    send_frame(1, 1'b0, 1'b0, 1'b1);
    fill_seq(5, 8'hA0);
    send_frame(1, 1'b0, 1'b0, 1'b1);
    total++;
    if (dcnt[1] !== 16'd1 || gcnt[1] !== 16'd1) begin
      bad++; $display("FAIL overflow drop=%0d good=%0d exp=1/1", dcnt[1], gcnt[1]);
    end
    read_frame(1, 1'b0, "ovf");
  endtask

  task automatic test_wrap();
    do_reset(1);
    fill_seq(40, 0);
    send_frame(1, 1'b0, 1'b0, 1'b1);
    read_frame(1, 1'b0, "wrap1");
    fill_rand(40);
    send_frame(1, 1'b0, 1'b0, 1'b1);
    read_frame(1, 1'b1, "wrap2");
  endtask

  task automatic test_queue_full();
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      fill_seq(1, i * 17 + 3);
      send_frame(1, 1'b0, 1'b0, 1'b1);
    end
    total++;
    if (gcnt[1] !== 16'd4 || dcnt[1] !== 16'd1) begin
      bad++; $display("FAIL qfull good=%0d drop=%0d exp=4/1", gcnt[1], dcnt[1]);
    end
    for (int i = 0; i < 4; i++) read_frame(1, 1'b0, "qfull");
    total++;
    if (bavail[1] !== 1'b0) begin
      bad++; $display("FAIL qfull_drained got=%b exp=0", bavail[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] whole [$];
    do_reset(0);
    fill_seq(10, 8'h55);
    send_frame(0, 1'b0, 1'b0, 1'b1);
    fill_seq(50, 8'h10);
    whole = fbytes;
    fbytes = whole[0:19];
    send_frame(0, 1'b0, 1'b0, 1'b0);
    do_reset(0);
    total++;
    if ({bdata[0], bvalid[0], blast[0], bavail[0]} !== 11'h000 || flen[0] !== 0) begin
      bad++; $display("FAIL rstmid_outs got=%h len=%0d exp=000/0", {bdata[0], bvalid[0], blast[0], bavail[0]}, flen[0]);
    end
    total++;
    if (gcnt[0] !== 16'd0 || dcnt[0] !== 16'd0) begin
      bad++; $display("FAIL rstmid_cnt good=%0d drop=%0d exp=0/0", gcnt[0], dcnt[0]);
    end
    fbytes = whole[20:49];
    send_frame(0, 1'b0, 1'b0, 1'b1);
    total++;
    if (gcnt[0] !== 16'd1 || flen[0] !== 30) begin
      bad++; $display("FAIL rstmid_commit good=%0d len=%0d exp=1/30", gcnt[0], flen[0]);
    end
    read_frame(0, 1'b0, "rstmid");
  endtask

  task automatic test_back_to_back();
    do_reset(0);
    fill_seq(100, 0);
    send_frame(0, 1'b0, 1'b0, 1'b1);
    fill_rand(100);
    fork
      send_frame(0, 1'b0, 1'b0, 1'b1);
      read_frame(0, 1'b0, "b2b_a");
    join
    read_frame(0, 1'b0, "b2b_b");
    total++;
    if (gcnt[0] !== 16'd2 || dcnt[0] !== 16'd0) begin
      bad++; $display("FAIL b2b_cnt good=%0d drop=%0d exp=2/0", gcnt[0], dcnt[0]);
    end
  endtask

  task automatic test_random(input int d, input int rounds, input int maxlen);
    int nf;
    int nr;
    do_reset(d);
    for (int r = 0; r < rounds; r++) begin
      nf = $urandom_range(1, 4);
      for (int f = 0; f < nf; f++) begin
        fill_rand($urandom_range(1, maxlen));
        send_frame(d, $urandom_range(0, 7) == 0, 1'b1, 1'b1);
      end
      total++;
      if (gcnt[d] !== 16'(eg) || dcnt[d] !== 16'(ed)) begin
        bad++; $display("FAIL rnd_cnt d=%0d good=%0d drop=%0d exp=%0d/%0d", d, gcnt[d], dcnt[d], eg, ed);
      end
      total++;
      if (bavail[d] !== 1'(mlens.size() > 0)) begin
        bad++; $display("FAIL rnd_avail d=%0d got=%b exp=%b", d, bavail[d], mlens.size() > 0);
      end
      nr = $urandom_range(0, mlens.size());
      for (int k = 0; k < nr; k++) read_frame(d, 1'b1, "rnd");
    end
    while (mlens.size() > 0) read_frame(d, 1'b1, "rnd_drain");
    total++;
    if (bavail[d] !== 1'b0) begin
      bad++; $display("FAIL rnd_drained d=%0d got=%b exp=0", d, bavail[d]);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; tdata[d] = 8'h00; tvalid[d] = 1'b0;
      tlast[d] = 1'b0; tuser[d] = 1'b0; rd_en[d] = 1'b0;
    end
    mocc = 0; eg = 0; ed = 0;
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_overflow();
    test_wrap();
    test_queue_full();
    test_reset_mid();
    test_back_to_back();
    test_random(1, 30, 70);
    test_random(0, 6, 700);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
